// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU MEM stage and
// a debug requester. Grant is combinational; the debug read response returns
// one cycle after its transfer.
// Build option: define DMEM_ARB_STARVE_EN to add the debug starvation guard.
// Without it the CPU has strict priority.

module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    // CPU side
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_dmtype,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    // debug side
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [2:0]  dbg_dmtype,
    output logic        dbg_rsp_valid,
    output logic [31:0] dbg_rdata,
    // memory side
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_dmtype,
    input  logic [31:0] mem_rdata
);

    // Owner of the previous cycle's access.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_DBG  = 2'd2;

    // Reject out-of-range starvation limits when the design is elaborated.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("dmem_port_arbiter: STARVE_LIMIT must be within 1..15");
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        force_grant;
    logic        cpu_grant;
    logic        dbg_grant;
    logic        dbg_xfer;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;

    assign force_grant = (wait_cnt_q >= LIMIT);

    // Wait counter: count cycles debug is left waiting, saturating at 15.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wait_cnt_d = '0;
        if (dbg_valid && !dbg_grant) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_grant = 1'b0;
`endif

    // Grant decision. A raised force flag only takes the port from the CPU
    // while debug is actually requesting; otherwise the CPU would stall with
    // nobody using the memory.
    always_comb begin
        cpu_grant = cpu_req && !(force_grant && dbg_valid);
        dbg_grant = dbg_valid && !cpu_grant;
        dbg_xfer  = dbg_grant;
    end

    // Memory port mux: the granted requester drives the port, idle otherwise.
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_dmtype = cpu_dmtype;
        if (cpu_grant) begin
            mem_en = 1'b1;
            mem_we = cpu_we;
        end else if (dbg_grant) begin
            mem_en     = 1'b1;
            mem_we     = dbg_we;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_dmtype = dbg_dmtype;
        end
    end

    // Requester handshakes and CPU load data.
    always_comb begin
        cpu_stall = cpu_req && !cpu_grant;
        cpu_rdata = mem_rdata;
        dbg_ready = dbg_grant;
    end

    // Owner FSM next state and debug read-data capture.
    always_comb begin
        state_d = ST_IDLE;
        if (cpu_grant) begin
            state_d = ST_CPU;
        end else if (dbg_grant) begin
            state_d = ST_DBG;
        end
        // Debug writes leave the previous read data in place.
        dbg_rdata_d = (dbg_xfer && !dbg_we) ? mem_rdata : dbg_rdata_q;
    end

    // Owner FSM and debug response registers; reset also drops a pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dbg_rdata_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_rsp_valid = (state_q == ST_DBG);
    assign dbg_rdata     = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter. The bench owns a small word
// memory behind the port; debug responses are checked through a scoreboard
// queue filled when a debug transfer is seen and drained on dbg_rsp_valid.
// Expectations for the starvation scenario follow DMEM_ARB_STARVE_EN.

module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_dmtype;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid, dbg_ready, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [2:0]  dbg_dmtype;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_dmtype;
    logic [31:0] mem_rdata;

    logic [31:0] mem_arr [0:255];
    logic [31:0] sb_q [$];
    logic [31:0] last_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[9:2]];

    dmem_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_dmtype   (cpu_dmtype),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .dbg_valid    (dbg_valid),
        .dbg_ready    (dbg_ready),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_dmtype   (dbg_dmtype),
        .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rdata    (dbg_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_dmtype   (mem_dmtype),
        .mem_rdata    (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Commit this cycle's memory write, then move to 1 time unit after the next edge.
    task automatic tick();
        if (mem_en === 1'b1 && mem_we === 1'b1) mem_arr[mem_addr[9:2]] = mem_wdata;
        @(posedge clk);
        #1;
    endtask

    // Let inputs settle, then run the response scoreboard for this cycle.
    task automatic settle();
        #1;
        if (reset) begin
            sb_q.delete();
            last_rdata = '0;
        end else begin
            if (dbg_rsp_valid) begin
                if (sb_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else check("rsp_data", dbg_rdata, sb_q.pop_front());
            end else if (sb_q.size() != 0) begin
                check("rsp_missing", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
            if (dbg_valid && dbg_ready) begin
                if (!dbg_we) last_rdata = mem_arr[dbg_addr[9:2]];
                sb_q.push_back(last_rdata);
            end
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_dmtype = 3'd2;
        dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_dmtype = 3'd2;
    endtask

    // CPU and debug both hold reads; debug should win only on every 9th cycle
    // with the guard built in, never without it. Also releases reset.
    task automatic starve_run(input int n);
        logic exp_dbg;
        for (int c = 1; c <= n; c++) begin
            tick();
            reset = 0;
            cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_dmtype = 3'd2;
            dbg_valid = 1; dbg_we = 0; dbg_addr = 32'h24; dbg_dmtype = 3'd5;
            settle();
`ifdef DMEM_ARB_STARVE_EN
            exp_dbg = (c % 9 == 0);
`else
            exp_dbg = 1'b0;
`endif
            check($sformatf("starve_ready_c%0d", c), dbg_ready, exp_dbg);
            check($sformatf("starve_stall_c%0d", c), cpu_stall, exp_dbg);
            check($sformatf("starve_addr_c%0d", c), mem_addr, exp_dbg ? 32'h24 : 32'h10);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA500_0000 | i;
        mem_arr[32'h10 >> 2] = 32'hDEAD_BEEF;
        mem_arr[32'h20 >> 2] = 32'h1234_5678;
        last_rdata = '0;
        reset = 1;
        idle_inputs();

        // Reset state, plus combinational outputs still live under reset.
        tick(); settle();
        check("rst_rsp_valid", dbg_rsp_valid, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_stall", cpu_stall, 0);
        cpu_req = 1; cpu_addr = 32'h10; settle();
        check("rst_cpu_mem_en", mem_en, 1);
        tick(); reset = 0; idle_inputs(); settle();

        // CPU load, no debug traffic.
        tick();
        cpu_req = 1; cpu_addr = 32'h10; cpu_dmtype = 3'd4;
        settle();
        check("cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("cpu_stall", cpu_stall, 0);
        check("cpu_mem_en", mem_en, 1);
        check("cpu_mem_we", mem_we, 0);
        check("cpu_mem_addr", mem_addr, 32'h10);
        check("cpu_dmtype", mem_dmtype, 3'd4);
        check("cpu_dbg_ready", dbg_ready, 0);

        // Single debug read with the CPU idle: ready in N, response in N+1 only.
        tick(); idle_inputs();
        dbg_valid = 1; dbg_addr = 32'h20; dbg_dmtype = 3'd1;
        settle();
        check("dbgrd_ready", dbg_ready, 1);
        check("dbgrd_mem_addr", mem_addr, 32'h20);
        check("dbgrd_dmtype", mem_dmtype, 3'd1);
        check("dbgrd_rsp_early", dbg_rsp_valid, 0);
        tick(); idle_inputs(); settle();
        check("dbgrd_rsp_n1", dbg_rsp_valid, 1);
        check("dbgrd_rdata_n1", dbg_rdata, 32'h1234_5678);
        tick(); settle();
        check("dbgrd_rsp_n2", dbg_rsp_valid, 0);
        check("dbgrd_rdata_hold", dbg_rdata, 32'h1234_5678);

        // Back-to-back debug: read, write, read-back, read.
        tick(); dbg_valid = 1; dbg_we = 0; dbg_addr = 32'h20; settle();
        check("b2b_ready0", dbg_ready, 1);
        tick(); dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'hCAFE_F00D; settle();
        check("b2b_ready1", dbg_ready, 1);
        check("b2b_rsp1", dbg_rsp_valid, 1);
        tick(); dbg_we = 0; dbg_addr = 32'h30; settle();
        check("b2b_ready2", dbg_ready, 1);
        check("b2b_rsp2", dbg_rsp_valid, 1);
        check("b2b_wr_hold", dbg_rdata, 32'h1234_5678);
        tick(); dbg_addr = 32'h8; settle();
        check("b2b_ready3", dbg_ready, 1);
        check("b2b_rsp3", dbg_rsp_valid, 1);
        check("b2b_readback", dbg_rdata, 32'hCAFE_F00D);
        tick(); idle_inputs(); settle();
        check("b2b_rsp4", dbg_rsp_valid, 1);
        check("b2b_last", dbg_rdata, 32'hA500_0002);
        tick(); settle();

        // Starvation guard under continuous contention.
        starve_run(12);
        tick(); idle_inputs(); settle();

        // Same-address write collision: only the CPU write reaches memory first.
        tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hA;
        dbg_valid = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hB;
        settle();
        check("coll_wdata", mem_wdata, 32'hA);
        check("coll_we", mem_we, 1);
        check("coll_stall", cpu_stall, 0);
        check("coll_dbg_ready", dbg_ready, 0);
        tick(); cpu_req = 0; cpu_we = 0; settle();
        check("coll_mem_cpu", mem_arr[16], 32'hA);
        check("coll_retry_ready", dbg_ready, 1);
        check("coll_retry_wdata", mem_wdata, 32'hB);
        tick(); idle_inputs(); settle();
        check("coll_mem_dbg", mem_arr[16], 32'hB);

        // Reset right after a debug transfer discards the pending response.
        tick(); dbg_valid = 1; dbg_addr = 32'h20; settle();
        check("rstp_ready", dbg_ready, 1);
        tick(); idle_inputs(); reset = 1; settle();
        check("rstp_rsp_now", dbg_rsp_valid, 0);
        check("rstp_rdata_now", dbg_rdata, 0);
        tick(); settle();
        tick(); reset = 0; settle();
        check("rstp_rsp_rel", dbg_rsp_valid, 0);
        check("rstp_rdata_rel", dbg_rdata, 0);
        tick(); settle();
        check("rstp_rsp_rel2", dbg_rsp_valid, 0);

        // Reset in the middle of a starvation run restarts the wait count.
        starve_run(5);
        tick(); reset = 1; settle();
        check("rsts_rsp", dbg_rsp_valid, 0);
        tick(); settle();
        starve_run(12);
        tick(); idle_inputs(); settle();
        tick(); settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive cycles a debug request waits before it is forced through (range 1..15).
REQ-002 SHALL have the following ports, clock and reset first; reset is asynchronous and active-high.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU data access this cycle (load or store).
- cpu_we  in  1  CPU store.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_dmtype  in  3  CPU access size/sign code, passed through unchanged.
- cpu_rdata  out  32  load data to CPU, valid in the granted cycle.
- cpu_stall  out  1  CPU access not granted this cycle; the CPU holds its MEM stage.
- dbg_valid  in  1  debug request valid.
- dbg_ready  out  1  debug request accepted this cycle.
- dbg_we, dbg_addr, dbg_wdata, dbg_dmtype  in  1/32/32/3  debug request fields.
- dbg_rsp_valid  out  1  debug response pulse.
- dbg_rdata  out  32  debug read data, held until the next response.
- mem_en, mem_we  out  1  memory access enable and write enable.
- mem_addr, mem_wdata  out  32  memory address and write data.
- mem_dmtype  out  3  memory size code.
- mem_rdata  in  32  combinational read data for the current mem_addr.

Function
REQ-003 SHALL decide the grant combinationally each cycle: CPU wins when cpu_req=1 and the force flag is 0; otherwise debug wins when dbg_valid=1.
REQ-004 SHALL drive mem_* from the granted requester; mem_en=0 and mem_we=0 when neither requests.
REQ-005 SHALL assert dbg_ready only in a cycle where debug is granted; a transfer occurs when dbg_valid and dbg_ready are both 1.
REQ-006 SHALL assert cpu_stall = cpu_req AND NOT cpu_granted; cpu_rdata = mem_rdata every cycle.
REQ-007 SHALL, on a debug transfer, register mem_rdata (reads) or hold the previous value (writes) into dbg_rdata, and pulse dbg_rsp_valid for exactly 1 cycle on the following cycle (latency 1).
REQ-008 SHALL keep a 3-state owner FSM, IDLE / CPU / DBG, recording the previous cycle's grant: the next state is CPU if CPU is granted, DBG if debug is granted, else IDLE; dbg_rsp_valid is asserted when the state is DBG.
REQ-009 SHALL keep a 4-bit wait counter: increment (saturating at 15) when dbg_valid=1 and debug is not granted; clear on a debug transfer or when dbg_valid=0.
REQ-010 SHALL compute the force flag as (wait counter >= STARVE_LIMIT); while it is set, debug is granted and cpu_stall=1 if cpu_req=1; forcing lasts exactly 1 transfer because the counter then clears.
REQ-011 SHALL allow back-to-back debug transfers on consecutive cycles when the CPU is idle, giving consecutive dbg_rsp_valid pulses.
REQ-012 SHALL, when both requesters write the same address in one cycle, let only the granted write reach memory; the loser retries unchanged.
REQ-013 SHALL produce no X on outputs when inputs are known; dbg_dmtype and cpu_dmtype are never modified.

Reset
REQ-014 SHALL, while reset=1, force: state=IDLE, wait counter=0, dbg_rsp_valid=0, dbg_rdata=0; combinational outputs follow REQ-003..006 with force=0.
REQ-015 SHALL discard a debug response pending at reset assertion: no dbg_rsp_valid after reset is released.

Configuration
REQ-016 SHALL implement the starvation guard (REQ-009, REQ-010) only when DMEM_ARB_STARVE_EN is defined; when undefined, the counter is removed, force is constant 0, and the CPU has strict priority.

Verification
REQ-017 SHALL cover: cpu_req=1, dbg_valid=0, load at 0x10 with mem_rdata=0xDEADBEEF -> cpu_rdata=0xDEADBEEF, cpu_stall=0, mem_en=1.
REQ-018 SHALL cover: CPU idle, debug read of 0x20 returning 0x12345678 -> dbg_ready=1 in cycle N; dbg_rsp_valid=1 and dbg_rdata=0x12345678 in cycle N+1 only.
REQ-019 SHALL cover: cpu_req held at 1 and dbg_valid held at 1, with STARVE_LIMIT=8 and the macro defined -> debug granted on the 9th cycle, cpu_stall=1 for that one cycle, CPU granted again on the next cycle.
REQ-020 SHALL cover: same stimulus as REQ-019 with the macro undefined -> debug is never granted and cpu_stall stays 0.
REQ-021 SHALL cover: both requesters write 0x40 in one cycle, CPU with 0xA, debug with 0xB -> mem_wdata=0xA; debug is written on the first CPU-idle cycle.
REQ-022 SHALL cover: reset asserted in the cycle after a debug transfer -> dbg_rsp_valid=0 immediately, and state/counter are at their reset values after release.
